dma_fifo_flex: RTL and testbench
================================

Name: dma_fifo_flex

Overview:
Next-generation synchronous DMA staging FIFO, a parametrised successor to the current power-of-2 DMA FIFO.
- Supports any depth ≥1, not just powers of 2.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags with software clear, and a high-watermark occupancy monitor.
- Optionally accepts a write while full when a read happens in the same cycle.
- Sits between the AXI read engine and the write engine as the per-channel data buffer.

Parameters:
- DEPTH, `DMA_FIFO_DEPTH (16): number of slots, any integer ≥1.
- WIDTH, `DMA_DATA_WIDTH (64): data width in bits.
- FULL_RW, 1: 1 = a write while full is accepted if a valid read occurs in the same cycle.
- CNT_W, $clog2(DEPTH+1): width of count outputs; derived, never overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of pointers, counts, watermark and sticky errors
- err_clr_i  in  1  synchronous clear of ovf_o/udf_o only
- write_i  in  1  push strobe
- read_i  in  1  pop strobe
- data_i  in  WIDTH  push data
- data_o  out  WIDTH  head entry, first-word fall-through
- afull_thr_i  in  CNT_W  almost-full threshold
- aempty_thr_i  in  CNT_W  almost-empty threshold
- full_o  out  1  ocup == DEPTH
- empty_o  out  1  ocup == 0
- afull_o  out  1  ocup ≥ afull_thr_i
- aempty_o  out  1  ocup ≤ aempty_thr_i
- ocup_o  out  CNT_W  current occupancy
- free_o  out  CNT_W  DEPTH − ocup
- max_ocup_o  out  CNT_W  highest occupancy since reset or clear
- ovf_o  out  1  sticky: write was rejected
- udf_o  out  1  sticky: read was rejected

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits (1 bit when DEPTH=1).
  - ocup_ff (CNT_W), max_ff, ovf_ff, udf_ff.
  - Storage array of DEPTH×WIDTH, not reset.
- Reset (async, rst_n=0): all state returns to 0. Outputs then read:
  - empty_o=1, full_o=0, ocup_o=0, free_o=DEPTH, max_ocup_o=0, ovf_o=0, udf_o=0.
  - data_o='0, aempty_o=1, afull_o=(afull_thr_i==0).
  - Reset may assert mid-transfer; in-flight data is discarded.
- Accept rules, evaluated on registered state:
  - rd_ok = read_i & ~empty_o.
  - wr_ok = write_i & (~full_o | (FULL_RW & rd_ok)).
- Pointer wrap: next = (ptr == DEPTH−1) ? 0 : ptr+1. This is explicit compare-and-wrap, never modulo-by-width.
- Occupancy update: ocup_ff += wr_ok − rd_ok.
  - Simultaneous accepted write and read leave it unchanged.
  - It never exceeds DEPTH and never underflows.
- Write: on wr_ok, mem[wr_ptr] <= data_i at the clock edge. The data is visible on data_o the next cycle if the FIFO was empty.
- data_o = empty_o ? '0 : mem[rd_ptr], combinational from registered state, zero-cycle read latency. A read on the same cycle as the first write to an empty FIFO is rejected (no bypass).
- Flags are combinational from ocup_ff only, so they are glitch-free with respect to write_i/read_i. Threshold compares are unsigned at CNT_W.
- Sticky errors:
  - ovf_ff sets on write_i & ~wr_ok.
  - udf_ff sets on read_i & ~rd_ok.
  - Both clear on clear_i or err_clr_i. A set in the same cycle as err_clr_i wins (set has priority).
- Watermark: max_ff <= max(max_ff, next ocup).
- clear_i has priority over write_i/read_i in the same cycle:
  - Pointers, ocup, max and errors go to 0.
  - The storage write is suppressed.
- DEPTH=1: the pointers are constant 0 and full/empty derive from ocup_ff[0].
- Elaboration assertions: DEPTH ≥ 1, WIDTH ≥ 1.

Decomposition:
- dma_pkg gains:
  - function fifo_cnt_w(depth) returning $clog2(depth+1);
  - typedef dma_fifo_status_t, a packed struct {full, empty, afull, aempty, ovf, udf} used by the channel CSR block.
- Sub-module dma_fifo_ptr: parametrised DEPTH wrap-around pointer with inc_i, clr_i and ptr_o. It is instantiated twice.

Test Plan:
- DEPTH=6, WIDTH=8: write 0x10..0x15 over 6 cycles → full_o=1, ocup_o=6, free_o=0; 7th write rejected, ovf_o=1, ocup_o stays 6.
- Same FIFO: 6 reads → data_o sequence 0x10..0x15 in order, empty_o=1, data_o=0; 7th read → udf_o=1. Then err_clr_i → both flags 0.
- FULL_RW=1, FIFO full: write 0xAA and read in the same cycle → both accepted, ocup stays 6. Continuing pushes and pops 20 times → correct order across pointer wrap 5→0.
- afull_thr_i=4, aempty_thr_i=1, fill 0→5 → aempty_o high at ocup 0–1, afull_o high from ocup 4; max_ocup_o=5 after draining to 2.
- At ocup=3, pulse clear_i together with write_i=1 → next cycle ocup_o=0, empty_o=1, max_ocup_o=0; the write is dropped.
- Assert rst_n=0 asynchronously mid-burst (between edges) → outputs take reset values immediately, before the next clock edge. DEPTH=1 variant: push/pop alternation and full/empty toggle every cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA types and helpers: FIFO sizing functions and the per-channel status bundle.
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 16
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

package dma_pkg;

  localparam int DMA_FIFO_DEPTH_DEF = `DMA_FIFO_DEPTH;
  localparam int DMA_DATA_WIDTH_DEF = `DMA_DATA_WIDTH;

  // Count outputs must hold the value DEPTH itself, hence depth+1.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } dma_fifo_status_t;

endpackage

// File: rtl/dma_fifo_ptr.sv
// Wrap-around slot pointer for an arbitrary-depth FIFO; wraps by compare, not by bit width.
module dma_fifo_ptr
  import dma_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  generate
    if (DEPTH == 1) begin : g_const
      // A single slot is always slot 0.
      logic unused;
      assign unused = ^{clk, rst_n, clr_i, inc_i};
      assign ptr_o  = '0;
    end else begin : g_wrap
      logic [PTR_W-1:0] ptr_ff;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_ff <= '0;
        end else if (clr_i) begin
          ptr_ff <= '0;
        end else if (inc_i) begin
          ptr_ff <= (ptr_ff == PTR_W'(DEPTH - 1)) ? '0 : ptr_ff + PTR_W'(1);
        end
      end

      assign ptr_o = ptr_ff;
    end
  endgenerate

endmodule

// File: rtl/dma_fifo_flex.sv
// Any-depth DMA staging FIFO with first-word fall-through output, thresholds,
// sticky overflow/underflow flags and a high-watermark occupancy monitor.
module dma_fifo_flex
  import dma_pkg::*;
#(
  parameter int DEPTH   = DMA_FIFO_DEPTH_DEF,
  parameter int WIDTH   = DMA_DATA_WIDTH_DEF,
  parameter bit FULL_RW = 1'b1,
  localparam int CNT_W  = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             err_clr_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  input  logic [CNT_W-1:0] afull_thr_i,
  input  logic [CNT_W-1:0] aempty_thr_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o,
  output logic             aempty_o,
  output logic [CNT_W-1:0] ocup_o,
  output logic [CNT_W-1:0] free_o,
  output logic [CNT_W-1:0] max_ocup_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("dma_fifo_flex: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("dma_fifo_flex: WIDTH must be >= 1");
    end
  endgenerate

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] ocup_ff;
  logic [CNT_W-1:0] ocup_nxt;
  logic [CNT_W-1:0] max_ff;
  logic             ovf_ff;
  logic             udf_ff;
  logic [WIDTH-1:0] mem [DEPTH];

  logic full;
  logic empty;
  logic rd_ok;
  logic wr_ok;
  logic wr_en;
  logic rd_en;

  generate
    if (DEPTH == 1) begin : g_flags_one
      assign full  = ocup_ff[0];
      assign empty = ~ocup_ff[0];
    end else begin : g_flags_multi
      assign full  = (ocup_ff == CNT_W'(DEPTH));
      assign empty = (ocup_ff == '0);
    end
  endgenerate

  // Handshake: write_i/read_i are single-cycle strobes with no ready; a strobe
  // is taken iff its *_ok term is high in that cycle, otherwise it sets the
  // matching sticky error. Acceptance looks only at registered occupancy.
  assign rd_ok = read_i & ~empty;
  assign wr_ok = write_i & (~full | (FULL_RW & rd_ok));

  // clear_i wins over traffic: no storage write, no pointer movement.
  assign wr_en = wr_ok & ~clear_i;
  assign rd_en = rd_ok & ~clear_i;

  always_comb begin
    ocup_nxt = ocup_ff;
    if (wr_ok && !rd_ok) begin
      ocup_nxt = ocup_ff + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      ocup_nxt = ocup_ff - CNT_W'(1);
    end
  end

  dma_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear_i),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  dma_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear_i),
    .inc_i (rd_en),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocup_ff <= '0;
      max_ff  <= '0;
      ovf_ff  <= 1'b0;
      udf_ff  <= 1'b0;
    end else if (clear_i) begin
      ocup_ff <= '0;
      max_ff  <= '0;
      ovf_ff  <= 1'b0;
      udf_ff  <= 1'b0;
    end else begin
      ocup_ff <= ocup_nxt;
      if (ocup_nxt > max_ff) begin
        max_ff <= ocup_nxt;
      end
      // A new error in the same cycle as err_clr_i must not be lost.
      if (write_i && !wr_ok) begin
        ovf_ff <= 1'b1;
      end else if (err_clr_i) begin
        ovf_ff <= 1'b0;
      end
      if (read_i && !rd_ok) begin
        udf_ff <= 1'b1;
      end else if (err_clr_i) begin
        udf_ff <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; empty_o masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_i;
    end
  end

  assign data_o     = empty ? '0 : mem[rd_ptr];
  assign full_o     = full;
  assign empty_o    = empty;
  assign afull_o    = (ocup_ff >= afull_thr_i);
  assign aempty_o   = (ocup_ff <= aempty_thr_i);
  assign ocup_o     = ocup_ff;
  assign free_o     = CNT_W'(DEPTH) - ocup_ff;
  assign max_ocup_o = max_ff;
  assign ovf_o      = ovf_ff;
  assign udf_o      = udf_ff;

endmodule

// File: tb/tb_dma_fifo_flex.sv
// Bench for dma_fifo_flex: a DEPTH=6 instance and a DEPTH=1 instance checked against queue models.
module tb_dma_fifo_flex;

  localparam int DEPTH_A = 6;

  logic clk;
  logic rst_n;

  // DEPTH=6 instance
  logic       a_clear, a_eclr, a_write, a_read;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_athr, a_ethr;
  logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [2:0] a_ocup, a_free, a_max;

  // DEPTH=1 instance
  logic       b_clear, b_eclr, b_write, b_read;
  logic [7:0] b_din, b_dout;
  logic [0:0] b_athr, b_ethr;
  logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [0:0] b_ocup, b_free, b_max;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_max;
  bit         m_ovf, m_udf;
  logic [7:0] bq[$];
  int         b_mmax;
  bit         b_movf, b_mudf;

  dma_fifo_flex #(.DEPTH(DEPTH_A), .WIDTH(8), .FULL_RW(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(a_clear), .err_clr_i(a_eclr),
    .write_i(a_write), .read_i(a_read), .data_i(a_din), .data_o(a_dout),
    .afull_thr_i(a_athr), .aempty_thr_i(a_ethr), .full_o(a_full), .empty_o(a_empty),
    .afull_o(a_afull), .aempty_o(a_aempty), .ocup_o(a_ocup), .free_o(a_free),
    .max_ocup_o(a_max), .ovf_o(a_ovf), .udf_o(a_udf)
  );

  dma_fifo_flex #(.DEPTH(1), .WIDTH(8), .FULL_RW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(b_clear), .err_clr_i(b_eclr),
    .write_i(b_write), .read_i(b_read), .data_i(b_din), .data_o(b_dout),
    .afull_thr_i(b_athr), .aempty_thr_i(b_ethr), .full_o(b_full), .empty_o(b_empty),
    .afull_o(b_afull), .aempty_o(b_aempty), .ocup_o(b_ocup), .free_o(b_free),
    .max_ocup_o(b_max), .ovf_o(b_ovf), .udf_o(b_udf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    int n;
    logic [7:0] head;
    n = mq.size();
    head = (n > 0) ? mq[0] : 8'h00;
    chk({tag, ":a_ocup"},   32'(a_ocup),   32'(n));
    chk({tag, ":a_free"},   32'(a_free),   32'(DEPTH_A - n));
    chk({tag, ":a_full"},   32'(a_full),   32'(n == DEPTH_A));
    chk({tag, ":a_empty"},  32'(a_empty),  32'(n == 0));
    chk({tag, ":a_afull"},  32'(a_afull),  32'(n >= int'(a_athr)));
    chk({tag, ":a_aempty"}, 32'(a_aempty), 32'(n <= int'(a_ethr)));
    chk({tag, ":a_max"},    32'(a_max),    32'(m_max));
    chk({tag, ":a_ovf"},    32'(a_ovf),    32'(m_ovf));
    chk({tag, ":a_udf"},    32'(a_udf),    32'(m_udf));
    chk({tag, ":a_data"},   32'(a_dout),   32'(head));
  endtask

  task automatic check_b(input string tag);
    int n;
    logic [7:0] head;
    n = bq.size();
    head = (n > 0) ? bq[0] : 8'h00;
    chk({tag, ":b_ocup"},   32'(b_ocup),   32'(n));
    chk({tag, ":b_free"},   32'(b_free),   32'(1 - n));
    chk({tag, ":b_full"},   32'(b_full),   32'(n == 1));
    chk({tag, ":b_empty"},  32'(b_empty),  32'(n == 0));
    chk({tag, ":b_afull"},  32'(b_afull),  32'(n >= int'(b_athr)));
    chk({tag, ":b_aempty"}, 32'(b_aempty), 32'(n <= int'(b_ethr)));
    chk({tag, ":b_max"},    32'(b_max),    32'(b_mmax));
    chk({tag, ":b_ovf"},    32'(b_ovf),    32'(b_movf));
    chk({tag, ":b_udf"},    32'(b_udf),    32'(b_mudf));
    chk({tag, ":b_data"},   32'(b_dout),   32'(head));
  endtask

  task automatic model_reset();
    mq.delete(); m_max = 0; m_ovf = 0; m_udf = 0;
    bq.delete(); b_mmax = 0; b_movf = 0; b_mudf = 0;
  endtask

  // Driver for the DEPTH=6 FIFO: one clock of traffic, then model update and check.
  task automatic step_a(input bit wr, input bit rd, input logic [7:0] din,
                        input bit clr, input bit eclr, input string tag);
    bit rd_ok, wr_ok;
    rd_ok = rd && (mq.size() > 0);
    wr_ok = wr && ((mq.size() < DEPTH_A) || rd_ok);
    a_write = wr; a_read = rd; a_din = din; a_clear = clr; a_eclr = eclr;
    @(posedge clk);
    if (clr) begin
      mq.delete(); m_max = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(din);
      if (mq.size() > m_max) m_max = mq.size();
      if (wr && !wr_ok) m_ovf = 1; else if (eclr) m_ovf = 0;
      if (rd && !rd_ok) m_udf = 1; else if (eclr) m_udf = 0;
    end
    #1;
    a_write = 0; a_read = 0; a_clear = 0; a_eclr = 0;
    check_a(tag);
  endtask

  task automatic step_b(input bit wr, input bit rd, input logic [7:0] din,
                        input bit eclr, input string tag);
    bit rd_ok, wr_ok;
    rd_ok = rd && (bq.size() > 0);
    wr_ok = wr && ((bq.size() < 1) || rd_ok);
    b_write = wr; b_read = rd; b_din = din; b_eclr = eclr;
    @(posedge clk);
    if (rd_ok) void'(bq.pop_front());
    if (wr_ok) bq.push_back(din);
    if (bq.size() > b_mmax) b_mmax = bq.size();
    if (wr && !wr_ok) b_movf = 1; else if (eclr) b_movf = 0;
    if (rd && !rd_ok) b_mudf = 1; else if (eclr) b_mudf = 0;
    #1;
    b_write = 0; b_read = 0; b_eclr = 0;
    check_b(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    a_clear = 0; a_eclr = 0; a_write = 0; a_read = 0; a_din = '0;
    b_clear = 0; b_eclr = 0; b_write = 0; b_read = 0; b_din = '0;
    a_athr = 3'd0; a_ethr = 3'd1; b_athr = 1'b1; b_ethr = 1'b0;
    model_reset();

    // Reset values, including afull with a zero threshold
    repeat (2) @(posedge clk);
    #1;
    check_a("reset_thr0");
    check_b("reset");
    a_athr = 3'd4;
    #1;
    check_a("reset_thr4");
    rst_n = 1'b1;

    // Fill 0x10..0x15, then overflow
    for (int i = 0; i < DEPTH_A; i++) step_a(1, 0, 8'h10 + 8'(i), 0, 0, "fill");
    chk("full_after_fill", 32'(a_full), 32'd1);
    step_a(1, 0, 8'h99, 0, 0, "ovf_write");
    chk("ovf_set", 32'(a_ovf), 32'd1);
    chk("ocup_held", 32'(a_ocup), 32'd6);

    // Drain in order, then underflow, then clear errors
    for (int i = 0; i < DEPTH_A; i++) begin
      chk("drain_order", 32'(a_dout), 32'(8'h10 + 8'(i)));
      step_a(0, 1, 8'h00, 0, 0, "drain");
    end
    step_a(0, 1, 8'h00, 0, 0, "udf_read");
    chk("udf_set", 32'(a_udf), 32'd1);
    step_a(0, 0, 8'h00, 0, 1, "err_clr");

    // Full + simultaneous read/write, then sustained push/pop across the wrap
    for (int i = 0; i < DEPTH_A; i++) step_a(1, 0, 8'($urandom), 0, 0, "refill");
    step_a(1, 1, 8'hAA, 0, 0, "full_rw");
    chk("full_rw_ocup", 32'(a_ocup), 32'd6);
    for (int i = 0; i < 20; i++) step_a(1, 1, 8'($urandom), 0, 0, "stream");
    for (int i = 0; i < DEPTH_A; i++) step_a(0, 1, 8'h00, 0, 0, "drain2");

    // Thresholds and watermark
    step_a(0, 0, 8'h00, 1, 0, "clr_max");
    a_athr = 3'd4; a_ethr = 3'd1;
    for (int i = 0; i < 5; i++) step_a(1, 0, 8'($urandom), 0, 0, "thr_fill");
    for (int i = 0; i < 3; i++) step_a(0, 1, 8'h00, 0, 0, "thr_drain");
    chk("watermark_5", 32'(a_max), 32'd5);

    // Clear with a concurrent write at ocup=3: write dropped
    step_a(1, 0, 8'h77, 0, 0, "to3");
    step_a(1, 0, 8'h55, 1, 0, "clr_wr");
    chk("clr_empty", 32'(a_empty), 32'd1);
    step_a(1, 0, 8'h42, 0, 0, "post_clr");

    // Randomized traffic with occasional clears and error clears
    for (int i = 0; i < 400; i++) begin
      bit wr, rd;
      if (i % 50 == 0) begin
        a_athr = 3'($urandom_range(0, 7));
        a_ethr = 3'($urandom_range(0, 7));
      end
      wr = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step_a(wr, rd, 8'($urandom), $urandom_range(0, 63) == 0,
             $urandom_range(0, 15) == 0, "rand");
    end

    // Asynchronous reset between clock edges while data is in flight
    a_athr = 3'd4; a_ethr = 3'd1;
    for (int i = 0; i < 4; i++) step_a(1, 0, 8'($urandom), 0, 0, "pre_rst");
    step_b(1, 0, 8'h3C, 0, "pre_rst_b");
    a_write = 1; a_din = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_a("async_rst");
    check_b("async_rst");
    a_write = 0;
    #2;
    rst_n = 1'b1;
    step_a(0, 0, 8'h00, 0, 0, "post_rst");

    // DEPTH=1: alternating push/pop toggles full/empty each cycle
    for (int i = 0; i < 8; i++) step_b(i % 2 == 0, i % 2 == 1, 8'($urandom), 0, "alt");
    step_b(1, 0, 8'h11, 0, "b_fill");
    step_b(1, 0, 8'h22, 0, "b_ovf");
    step_b(1, 1, 8'h33, 0, "b_full_rw");
    step_b(0, 1, 8'h00, 0, "b_pop");
    step_b(0, 1, 8'h00, 0, "b_udf");
    step_b(1, 0, 8'h44, 1, "b_errclr_set");
    step_b(0, 0, 8'h00, 1, "b_errclr");
    for (int i = 0; i < 40; i++)
      step_b($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom),
             $urandom_range(0, 7) == 0, "b_rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
